// File: rtl/dcache_ram_nway.sv
// N-way data/tag RAM for the data cache: 1-cycle registered lookup, byte-masked writes, tag invalidation sweep.
// Optional build macro DCACHE_BYPASS_EN forwards same-set write data/tags into the lookup (default: read-first).
//
// state | meaning
// IDLE  | normal lookup and write service
// CLEAR | invalidation sweep, writes tag 0 to every way at set ptr
module dcache_ram_nway #(
   parameter int WAYS       = 2,
   parameter int SETS_LOG2  = 10,
   parameter int LINE_BYTES = 16,
   parameter int TAG_W      = 22,
   localparam int WW        = (WAYS > 1) ? $clog2(WAYS) : 1,
   localparam int DW        = 8 * LINE_BYTES
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [SETS_LOG2-1:0] A,
   input  logic                 WEN,
   input  logic [WW-1:0]        WAY,
   input  logic [LINE_BYTES-1:0] M,
   input  logic [DW-1:0]        D,
   input  logic                 TWE,
   input  logic [TAG_W-1:0]     TD,
   input  logic [TAG_W-2:0]     TAGIN,
   input  logic                 FLUSH,
   output logic [DW-1:0]        Q,
   output logic [TAG_W-1:0]     QT,
   output logic                 HIT,
   output logic [WW-1:0]        HITWAY,
   output logic                 BUSY
);

   localparam int DEPTH = 1 << SETS_LOG2;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t               state_q, state_d;
   logic [SETS_LOG2-1:0] ptr_q, ptr_d;
   logic                 busy;
   logic                 wr_en;

   logic [DW-1:0]        data_mem [WAYS][DEPTH];
   logic [TAG_W-1:0]     tag_mem  [WAYS][DEPTH];

   logic [DW-1:0]        rd_data [WAYS];
   logic [TAG_W-1:0]     rd_tag  [WAYS];
   logic                 hit_d;
   logic [WW-1:0]        hw_d;
   logic [DW-1:0]        q_d;
   logic [TAG_W-1:0]     qt_d;

   assign busy  = (state_q == CLEAR);
   assign BUSY  = busy;
   assign wr_en = !WEN && !busy;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (FLUSH) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         CLEAR: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == '1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset parks the FSM in CLEAR so every release starts a full sweep from set 0.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int w = 0; w < WAYS; w++) begin
         if (busy)
            tag_mem[w][ptr_q] <= '0;
         else if (wr_en && TWE && (w == int'(WAY)))
            tag_mem[w][A] <= TD;
         if (wr_en && (w == int'(WAY))) begin
            for (int b = 0; b < LINE_BYTES; b++)
               if (M[b]) data_mem[w][A][8*b +: 8] <= D[8*b +: 8];
         end
      end
   end

`ifdef DCACHE_BYPASS_EN
   logic [DW-1:0] bmask;

   always_comb begin
      bmask = '0;
      for (int b = 0; b < LINE_BYTES; b++)
         bmask[8*b +: 8] = {8{M[b]}};
   end
`endif

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         rd_data[w] = data_mem[w][A];
         rd_tag[w]  = tag_mem[w][A];
`ifdef DCACHE_BYPASS_EN
         if (wr_en && (w == int'(WAY))) begin
            rd_data[w] = (rd_data[w] & ~bmask) | (D & bmask);
            if (TWE) rd_tag[w] = TD;
         end
`endif
      end
   end

   // Scanning from the top down leaves the lowest-numbered matching way selected.
   always_comb begin
      hit_d = 1'b0;
      hw_d  = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (rd_tag[w] == {1'b1, TAGIN}) begin
            hit_d = 1'b1;
            hw_d  = WW'(w);
         end
      end
      q_d  = rd_data[hw_d];
      qt_d = rd_tag[hw_d];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         Q      <= '0;
         QT     <= '0;
         HIT    <= 1'b0;
         HITWAY <= '0;
      end else if (busy) begin
         HIT    <= 1'b0;
      end else begin
         Q      <= q_d;
         QT     <= qt_d;
         HIT    <= hit_d;
         HITWAY <= hw_d;
      end
   end

endmodule

// File: tb/tb_dcache_ram_nway.sv
// Directed bench for dcache_ram_nway at default parameters (2 ways, 1024 sets, 16-byte lines, 22-bit tags).
module tb_dcache_ram_nway;

   logic         clk = 1'b0;
   logic         rstn;
   logic [9:0]   A;
   logic         WEN;
   logic [0:0]   WAY;
   logic [15:0]  M;
   logic [127:0] D;
   logic         TWE;
   logic [21:0]  TD;
   logic [20:0]  TAGIN;
   logic         FLUSH;
   logic [127:0] Q;
   logic [21:0]  QT;
   logic         HIT;
   logic [0:0]   HITWAY;
   logic         BUSY;

   int nvec = 0;
   int nerr = 0;
   int bcnt;

   localparam logic [127:0] D5A  = {16{8'h5A}};
   localparam logic [127:0] DFF  = {16{8'hFF}};
   localparam logic [127:0] D11  = {16{8'h11}};
   localparam logic [127:0] DA0  = {16{8'hA0}};
   localparam logic [127:0] DB1  = {16{8'hB1}};
   localparam logic [127:0] DEE  = {16{8'hEE}};
   localparam logic [127:0] D5AF = {{15{8'h5A}}, 8'hFF};

   dcache_ram_nway dut (
      .clk(clk), .rstn(rstn), .A(A), .WEN(WEN), .WAY(WAY), .M(M), .D(D),
      .TWE(TWE), .TD(TD), .TAGIN(TAGIN), .FLUSH(FLUSH),
      .Q(Q), .QT(QT), .HIT(HIT), .HITWAY(HITWAY), .BUSY(BUSY)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic [9:0] a, input logic wen, input logic way, input logic [15:0] m,
                      input logic [127:0] d, input logic twe, input logic [21:0] td,
                      input logic [20:0] tagin, input logic fl);
      @(negedge clk);
      A = a; WEN = wen; WAY = way; M = m; D = d; TWE = twe; TD = td; TAGIN = tagin; FLUSH = fl;
      @(posedge clk);
      #1;
      WEN = 1'b1; FLUSH = 1'b0; TWE = 1'b0;
   endtask

   task automatic wr(input logic way, input logic [9:0] a, input logic [15:0] m,
                     input logic [127:0] d, input logic twe, input logic [21:0] td);
      cyc(a, 1'b0, way, m, d, twe, td, 21'h0, 1'b0);
   endtask

   task automatic rd(input logic [9:0] a, input logic [20:0] tagin);
      cyc(a, 1'b1, 1'b0, 16'h0, 128'h0, 1'b0, 22'h0, tagin, 1'b0);
   endtask

   task automatic busy_run(input int lim);
      WEN = 1'b1; FLUSH = 1'b0; TWE = 1'b0;
      while (BUSY && bcnt < lim) begin
         bcnt++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [20:0] t;
      rstn = 1'b0; A = '0; WEN = 1'b1; WAY = '0; M = '0; D = '0;
      TWE = 1'b0; TD = '0; TAGIN = '0; FLUSH = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_q",      Q, 128'h0);
      check("rst_qt",     128'(QT), 128'h0);
      check("rst_hit",    128'(HIT), 128'h0);
      check("rst_hitway", 128'(HITWAY), 128'h0);
      check("rst_busy",   128'(BUSY), 128'h1);

      rstn = 1'b1;
      bcnt = 0;
      busy_run(3000);
      check("rst_sweep_len", 128'(bcnt), 128'd1024);

      for (int s = 0; s < 1024; s++) begin
         t = 21'($urandom);
         rd(10'(s), t);
         check("scan_hit", 128'(HIT), 128'h0);
      end

      wr(1'b1, 10'h2A5, 16'hFFFF, D5A, 1'b1, 22'h3FFFFF);
      rd(10'h2A5, 21'h1FFFFF);
      check("w1_hit",    128'(HIT), 128'h1);
      check("w1_hitway", 128'(HITWAY), 128'h1);
      check("w1_q",      Q, D5A);
      check("w1_qt",     128'(QT), 128'h3FFFFF);

      wr(1'b1, 10'h2A5, 16'h0001, DFF, 1'b0, 22'h0);
      rd(10'h2A5, 21'h1FFFFF);
      check("mask_q", Q, D5AF);

      cyc(10'h2A5, 1'b0, 1'b1, 16'hFFFF, D11, 1'b0, 22'h0, 21'h1FFFFF, 1'b0);
`ifdef DCACHE_BYPASS_EN
      check("raw_q", Q, D11);
`else
      check("raw_q", Q, D5AF);
`endif
      check("raw_hit", 128'(HIT), 128'h1);
      rd(10'h2A5, 21'h1FFFFF);
      check("after_raw_q", Q, D11);

      wr(1'b0, 10'h010, 16'hFFFF, DA0, 1'b1, 22'h200123);
      wr(1'b1, 10'h010, 16'hFFFF, DB1, 1'b1, 22'h200123);
      rd(10'h010, 21'h000123);
      check("dup_hit",    128'(HIT), 128'h1);
      check("dup_hitway", 128'(HITWAY), 128'h0);
      check("dup_q",      Q, DA0);

      wr(1'b0, 10'h020, 16'h0000, DFF, 1'b1, 22'h000055);
      rd(10'h020, 21'h000055);
      check("inval_hit", 128'(HIT), 128'h0);
      check("inval_qt",  128'(QT), 128'h000055);

      wr(1'b0, 10'h010, 16'h0000, DFF, 1'b0, 22'h0);
      rd(10'h010, 21'h000123);
      check("nop_hit", 128'(HIT), 128'h1);
      check("nop_q",   Q, DA0);

      cyc(10'h010, 1'b1, 1'b0, 16'h0, 128'h0, 1'b0, 22'h0, 21'h000123, 1'b1);
      check("flush_busy", 128'(BUSY), 128'h1);
      bcnt = 0;
      busy_run(5);
      cyc(10'h2A5, 1'b0, 1'b1, 16'hFFFF, DEE, 1'b1, 22'h3FFFFF, 21'h1FFFFF, 1'b1);
      bcnt++;
      check("busy_hit", 128'(HIT), 128'h0);
      check("busy_q",   Q, DA0);
      busy_run(3000);
      check("flush_len", 128'(bcnt), 128'd1024);
      rd(10'h010, 21'h000123);
      check("flushed_hit_a", 128'(HIT), 128'h0);
      check("flushed_qt_a",  128'(QT), 128'h0);
      rd(10'h2A5, 21'h1FFFFF);
      check("flushed_hit_b", 128'(HIT), 128'h0);

      wr(1'b0, 10'h100, 16'h0, 128'h0, 1'b1, 22'h200100);
      wr(1'b1, 10'h3FF, 16'h0, 128'h0, 1'b1, 22'h2003FF);
      rd(10'h3FF, 21'h0003FF);
      check("pre_hit",    128'(HIT), 128'h1);
      check("pre_hitway", 128'(HITWAY), 128'h1);
      cyc(10'h000, 1'b1, 1'b0, 16'h0, 128'h0, 1'b0, 22'h0, 21'h0, 1'b1);
      bcnt = 0;
      busy_run(500);
      check("mid_sweep_busy", 128'(BUSY), 128'h1);
      rstn = 1'b0;
      #2;
      check("mid_rst_q",    Q, 128'h0);
      check("mid_rst_qt",   128'(QT), 128'h0);
      check("mid_rst_hit",  128'(HIT), 128'h0);
      check("mid_rst_busy", 128'(BUSY), 128'h1);
      @(negedge clk);
      rstn = 1'b1;
      bcnt = 0;
      busy_run(3000);
      check("restart_len", 128'(bcnt), 128'd1024);
      rd(10'h100, 21'h000100);
      check("post_hit_a", 128'(HIT), 128'h0);
      rd(10'h3FF, 21'h0003FF);
      check("post_hit_b", 128'(HIT), 128'h0);

      wr(1'b1, 10'h2A5, 16'h0000, 128'h0, 1'b1, 22'h3FFFFF);
      rd(10'h2A5, 21'h1FFFFF);
      check("keep_hit", 128'(HIT), 128'h1);
      check("keep_q",   Q, D11);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
